// File: rtl/pipeline_pkg.sv
// pipeline_pkg: opcodes, sequencer states and PC source encodings shared by the hazard logic
package pipeline_pkg;
  localparam logic [3:0] ATYPE = 4'b0001;
  localparam logic [3:0] LBU   = 4'b0100;
  localparam logic [3:0] SB    = 4'b0101;
  localparam logic [3:0] LW    = 4'b0110;
  localparam logic [3:0] SW    = 4'b0111;
  localparam logic [3:0] JMP   = 4'b1011;
  localparam logic [3:0] BLT   = 4'b1100;
  localparam logic [3:0] BGT   = 4'b1101;
  localparam logic [3:0] BEQ   = 4'b1110;
  localparam logic [3:0] HALT  = 4'b1111;
  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;
  function automatic logic is_load(input logic [3:0] op);
    return op == LBU || op == LW;
  endfunction
  function automatic logic is_mem(input logic [3:0] op);
    return op == LBU || op == SB || op == LW || op == SW;
  endfunction
  function automatic logic is_branch(input logic [3:0] op);
    return op == BLT || op == BGT || op == BEQ;
  endfunction
endpackage

// File: rtl/pipeline_hazard_sequencer_hazard_detect.sv
// hazard_detect: flags a load in EX whose destination feeds a source of the instruction in ID
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [3:0] opcode_ex,
  input  logic [3:0] rd_ex,
  input  logic [3:0] rs1_id,
  input  logic [3:0] rs2_id,
  input  logic       uses_rs2_id,
  output logic       load_use
);
  assign load_use = is_load(opcode_ex) && rd_ex != 4'd0 &&
                    (rd_ex == rs1_id || (uses_rs2_id && rd_ex == rs2_id));
endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// pipeline_hazard_sequencer: stall/flush/halt control for the 5-stage pipeline
module pipeline_hazard_sequencer
  import pipeline_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       opcode_id,
  input  logic [3:0]       rs1_id,
  input  logic [3:0]       rs2_id,
  input  logic             uses_rs2_id,
  input  logic [3:0]       opcode_ex,
  input  logic [3:0]       rd_ex,
  input  logic [3:0]       opcode_mem,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic [1:0]       pc_src,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int MW_W = $clog2(MEM_TIMEOUT + 1);
  localparam int DC_W = $clog2(DRAIN_CYCLES + 1);
  state_t state, next_state;
  logic [MW_W-1:0] mem_wait_cnt;
  logic [DC_W-1:0] drain_cnt;
  logic load_use, mem_stall, timeout_hit, drain_done;
  hazard_detect u_hazard_detect (
    .opcode_ex   (opcode_ex),
    .rd_ex       (rd_ex),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .uses_rs2_id (uses_rs2_id),
    .load_use    (load_use)
  );
  assign mem_stall   = is_mem(opcode_mem) && !mem_ready && state != HALTED;
  assign timeout_hit = mem_stall && mem_wait_cnt == MW_W'(MEM_TIMEOUT - 1);
  assign drain_done  = drain_cnt == DC_W'(DRAIN_CYCLES - 1);
  assign halted      = state == HALTED;
  // Mealy decode of enables/flushes and next state, in priority mem wait > load-use > halt > branch/jump
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    memwb_write = 1'b1;
    pc_src      = PC_SEQ;
    next_state  = state;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
    end else begin
      case (state)
        RUN, MEM_WAIT: begin
          next_state = RUN;
          if (mem_stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
            next_state  = timeout_hit ? RUN : MEM_WAIT;
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end else if (opcode_id == HALT) begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
            next_state = DRAIN;
          end else if (is_branch(opcode_id) && branch_taken) begin
            pc_src     = PC_BRANCH;
            ifid_flush = 1'b1;
          end else if (opcode_id == JMP) begin
            pc_src     = PC_JUMP;
            ifid_flush = 1'b1;
          end
        end
        DRAIN: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          exmem_write = !mem_stall;
          memwb_write = !mem_stall;
          idex_flush  = !mem_stall;
          next_state  = (!mem_stall && drain_done) ? HALTED : DRAIN;
        end
        default: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          exmem_write = 1'b0;
          memwb_write = 1'b0;
        end
      endcase
    end
  end
  // State, drain/mem-wait counters, sticky timeout flag and saturating stall counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RUN;
      drain_cnt    <= '0;
      mem_wait_cnt <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state        <= next_state;
      drain_cnt    <= state != DRAIN ? '0 : mem_stall ? drain_cnt : drain_cnt + DC_W'(1);
      mem_wait_cnt <= (mem_stall && !timeout_hit) ? mem_wait_cnt + MW_W'(1) : '0;
      if (timeout_hit) mem_timeout <= 1'b1;
      if (!pc_write && state != HALTED && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// tb_pipeline_hazard_sequencer: scoreboard bench with hand-derived per-cycle control expectations
module tb_pipeline_hazard_sequencer;
  import pipeline_pkg::*;
  // control vector: pc_write, ifid_write, ifid_flush, idex_flush, exmem_write, memwb_write, pc_src[1:0], halted
  localparam logic [8:0] NORM = 9'b1_1_0_0_1_1_00_0;
  localparam logic [8:0] LUSE = 9'b0_0_0_1_1_1_00_0;
  localparam logic [8:0] FRZ  = 9'b0_0_0_0_0_0_00_0;
  localparam logic [8:0] BR   = 9'b1_1_1_0_1_1_01_0;
  localparam logic [8:0] JP   = 9'b1_1_1_0_1_1_10_0;
  localparam logic [8:0] HLT  = 9'b0_1_1_0_1_1_00_0;
  localparam logic [8:0] DRN  = 9'b0_0_0_1_1_1_00_0;
  localparam logic [8:0] HLD  = 9'b0_0_0_0_0_0_00_1;
  localparam logic [8:0] RST  = 9'b0_0_1_1_0_0_00_0;
  localparam logic [8:0] RSTH = 9'b0_0_1_1_0_0_00_1;
  typedef struct {
    logic [8:0]  ctl;
    logic        to;
    logic [15:0] sc;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] opcode_id, rs1_id, rs2_id, opcode_ex, rd_ex, opcode_mem;
  logic uses_rs2_id, mem_ready, branch_taken;
  logic pc_write, ifid_write, ifid_flush, idex_flush, exmem_write, memwb_write, halted, mem_timeout;
  logic [1:0] pc_src;
  logic [15:0] stall_cycles;
  logic [8:0] obs_ctl;
  exp_t sb[$];
  string tags[$];
  int n_checks = 0, n_fail = 0;
  logic to_exp = 1'b0;
  logic [15:0] sc_exp = '0;
  always #5 clk = ~clk;
  assign obs_ctl = {pc_write, ifid_write, ifid_flush, idex_flush, exmem_write, memwb_write, pc_src, halted};
  pipeline_hazard_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode_id    (opcode_id),
    .rs1_id       (rs1_id),
    .rs2_id       (rs2_id),
    .uses_rs2_id  (uses_rs2_id),
    .opcode_ex    (opcode_ex),
    .rd_ex        (rd_ex),
    .opcode_mem   (opcode_mem),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_write  (exmem_write),
    .memwb_write  (memwb_write),
    .pc_src       (pc_src),
    .halted       (halted),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drv(input logic [3:0] oi, input logic [3:0] r1, input logic [3:0] r2, input logic u2,
                     input logic [3:0] oe, input logic [3:0] rd, input logic [3:0] om, input logic mr,
                     input logic bt);
    opcode_id = oi; rs1_id = r1; rs2_id = r2; uses_rs2_id = u2;
    opcode_ex = oe; rd_ex = rd; opcode_mem = om; mem_ready = mr; branch_taken = bt;
  endtask
  task automatic nop();
    drv(ATYPE, 4'd0, 4'd0, 1'b0, ATYPE, 4'd0, ATYPE, 1'b1, 1'b0);
  endtask
  task automatic step(input string tag, input logic [8:0] ctl);
    exp_t e;
    string t;
    sb.push_back('{ctl, to_exp, sc_exp});
    tags.push_back(tag);
    if (!rst_n) sc_exp = '0;
    else if (!ctl[8] && !ctl[0] && sc_exp != 16'hffff) sc_exp++;
    @(negedge clk);
    e = sb.pop_front();
    t = tags.pop_front();
    check({t, "/ctl"}, 32'(obs_ctl), 32'(e.ctl));
    check({t, "/mem_timeout"}, 32'(mem_timeout), 32'(e.to));
    check({t, "/stall_cycles"}, 32'(stall_cycles), 32'(e.sc));
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    nop();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    step("reset", RST);
    rst_n = 1'b1;
    step("idle", NORM);
    drv(ATYPE, 4'd3, 4'd0, 1'b0, LW, 4'd3, ATYPE, 1'b1, 1'b0);
    step("lu_rs1", LUSE);
    drv(ATYPE, 4'd3, 4'd0, 1'b0, 4'd0, 4'd0, LW, 1'b1, 1'b0);
    step("lu_after", NORM);
    drv(ATYPE, 4'd0, 4'd0, 1'b1, LW, 4'd0, ATYPE, 1'b1, 1'b0);
    step("lu_rd0", NORM);
    drv(ATYPE, 4'd5, 4'd3, 1'b0, LW, 4'd3, ATYPE, 1'b1, 1'b0);
    step("lu_rs2_unused", NORM);
    drv(ATYPE, 4'd5, 4'd3, 1'b1, LW, 4'd3, ATYPE, 1'b1, 1'b0);
    step("lu_rs2", LUSE);
    drv(ATYPE, 4'd7, 4'd0, 1'b0, LBU, 4'd7, ATYPE, 1'b1, 1'b0);
    step("lu_lbu", LUSE);
    drv(ATYPE, 4'd7, 4'd0, 1'b0, SW, 4'd7, ATYPE, 1'b1, 1'b0);
    step("no_lu_store", NORM);
    drv(BEQ, 4'd1, 4'd2, 1'b1, ATYPE, 4'd0, ATYPE, 1'b1, 1'b1);
    step("beq_taken", BR);
    drv(BEQ, 4'd1, 4'd2, 1'b1, ATYPE, 4'd0, ATYPE, 1'b1, 1'b0);
    step("beq_not", NORM);
    drv(BLT, 4'd1, 4'd2, 1'b1, ATYPE, 4'd0, ATYPE, 1'b1, 1'b1);
    step("blt_taken", BR);
    drv(JMP, 4'd0, 4'd0, 1'b0, ATYPE, 4'd0, ATYPE, 1'b1, 1'b0);
    step("jmp", JP);
    drv(ATYPE, 4'd0, 4'd0, 1'b0, ATYPE, 4'd0, LW, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step($sformatf("memwait%0d", i), FRZ);
    mem_ready = 1'b1;
    step("memwait_exit", NORM);
    drv(ATYPE, 4'd0, 4'd0, 1'b0, ATYPE, 4'd0, SB, 1'b0, 1'b0);
    step("memwait_sb", FRZ);
    drv(ATYPE, 4'd0, 4'd0, 1'b0, ATYPE, 4'd0, ATYPE, 1'b0, 1'b0);
    step("no_wait_alu", NORM);
    drv(ATYPE, 4'd4, 4'd0, 1'b0, LW, 4'd4, LW, 1'b0, 1'b0);
    step("combo_frz0", FRZ);
    step("combo_frz1", FRZ);
    mem_ready = 1'b1;
    step("combo_bubble", LUSE);
    drv(ATYPE, 4'd4, 4'd0, 1'b0, 4'd0, 4'd0, LW, 1'b1, 1'b0);
    step("combo_after", NORM);
    drv(BEQ, 4'd2, 4'd0, 1'b0, LW, 4'd2, ATYPE, 1'b1, 1'b1);
    step("lu_over_branch", LUSE);
    drv(BEQ, 4'd2, 4'd0, 1'b0, 4'd0, 4'd0, LW, 1'b1, 1'b1);
    step("branch_after_lu", BR);
    drv(ATYPE, 4'd0, 4'd0, 1'b0, ATYPE, 4'd0, LW, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      to_exp = (i >= 255);
      step($sformatf("timeout%0d", i), FRZ);
    end
    nop();
    step("timeout_release", NORM);
    drv(HALT, 4'd0, 4'd0, 1'b0, ATYPE, 4'd0, ATYPE, 1'b1, 1'b0);
    step("halt", HLT);
    nop();
    step("drain0", DRN);
    drv(JMP, 4'd0, 4'd0, 1'b0, ATYPE, 4'd0, SW, 1'b0, 1'b0);
    step("drain_frz0", FRZ);
    step("drain_frz1", FRZ);
    nop();
    step("drain1", DRN);
    step("drain2", DRN);
    drv(JMP, 4'd0, 4'd0, 1'b0, ATYPE, 4'd0, ATYPE, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step($sformatf("halted%0d", i), HLD);
    rst_n = 1'b0;
    step("rst_from_halt", RSTH);
    rst_n = 1'b1;
    to_exp = 1'b0;
    nop();
    step("after_rst", NORM);
    drv(HALT, 4'd0, 4'd0, 1'b0, ATYPE, 4'd0, ATYPE, 1'b1, 1'b0);
    step("halt_b", HLT);
    nop();
    step("drain_b0", DRN);
    rst_n = 1'b0;
    step("rst_mid_drain", RST);
    rst_n = 1'b1;
    step("idle_b", NORM);
    drv(HALT, 4'd0, 4'd0, 1'b0, ATYPE, 4'd0, ATYPE, 1'b1, 1'b0);
    step("halt_c", HLT);
    nop();
    for (int i = 0; i < 3; i++) step($sformatf("drain_c%0d", i), DRN);
    step("halted_c0", HLD);
    step("halted_c1", HLD);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_sequencer.md
Name: pipeline_hazard_sequencer

Overview:
Central stall/flush/halt sequencer for the 5-stage pipeline. It sits beside the stage control decoder, watches the opcodes and register fields in ID/EX/MEM, and drives the PC and pipeline-register enables and flushes. It inserts load-use bubbles, redirects on taken branch or jump, freezes the pipeline while data memory is busy, and drains in-flight instructions on HALT. It also keeps a saturating stall-cycle counter and flags memory timeouts.

Parameters:
DRAIN_CYCLES, 3, cycles to retire instructions behind HALT (EX, MEM, WB)
MEM_TIMEOUT, 255, max consecutive mem_ready-low cycles before mem_timeout
CNT_W, 16, width of stall_cycles

Ports:
clk  in  1  single clock; all state on rising edge
rst_n  in  1  synchronous, active-low reset
opcode_id  in  4  opcode in ID
rs1_id  in  4  ID source reg 1
rs2_id  in  4  ID source reg 2
uses_rs2_id  in  1  ID instruction reads rs2
opcode_ex  in  4  opcode in EX
rd_ex  in  4  EX destination reg
opcode_mem  in  4  opcode in MEM
mem_ready  in  1  data memory done this cycle
branch_taken  in  1  ID comparator result for BLT/BGT/BEQ
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID enable
ifid_flush  out  1  zero IF/ID (kill fetched instr)
idex_flush  out  1  insert bubble into ID/EX
exmem_write  out  1  EX/MEM enable
memwb_write  out  1  MEM/WB enable
pc_src  out  2  00 PC+2, 01 branch target, 10 jump target
halted  out  1  pipeline stopped after HALT
mem_timeout  out  1  sticky memory timeout error
stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- rst_n low at an edge: state=RUN, drain_cnt=0, mem_wait_cnt=0, halted=0, mem_timeout=0, stall_cycles=0. While rst_n is low, outputs are forced: all write enables 0, ifid_flush=1, idex_flush=1, pc_src=00. Reset mid-drain or mid-wait aborts it with no residue.
- States: RUN, MEM_WAIT, DRAIN, HALTED. Outputs are Mealy, decoded from state plus current inputs, with zero latency.
- Defaults in RUN: every write enable 1, flushes 0, pc_src=00.
- Priority when events coincide: mem wait > load-use > halt > branch/jump.
- Mem wait: opcode_mem is a load or store and mem_ready=0 -> all writes 0, no flush; go to MEM_WAIT. Exit to RUN on the first cycle mem_ready=1. That cycle uses normal RUN decode.
- Mem wait counter: counts cycles in the wait. When it reaches MEM_TIMEOUT, set mem_timeout (sticky until reset) and force exit to RUN.
- Load-use: opcode_ex is LBU/LW, rd_ex!=0, and rd_ex==rs1_id or (uses_rs2_id and rd_ex==rs2_id) -> pc_write=0, ifid_write=0, idex_flush=1 for one cycle. Branch/jump/halt in ID waits behind this stall.
- Branch: opcode_id is BLT/BGT/BEQ and branch_taken=1 -> pc_src=01, ifid_flush=1.
- Jump: opcode_id is JMP -> pc_src=10, ifid_flush=1.
- Halt: opcode_id is HALT -> pc_write=0, ifid_flush=1, then DRAIN.
- DRAIN: pc_write=0, ifid_write=0, idex_flush=1; EX/MEM and MEM/WB still advance. After DRAIN_CYCLES cycles go to HALTED. A mem wait during DRAIN freezes drain_cnt.
- HALTED: halted=1, all writes 0. Left only by reset.
- stall_cycles: +1 on every cycle in which pc_write=0 and state!=HALTED. Saturates at all-ones, no wrap.

Decomposition:
- Package pipeline_pkg holds the opcode constants: ATYPE=0001, LBU=0100, SB=0101, LW=0110, SW=0111, JMP=1011, BLT=1100, BGT=1101, BEQ=1110, HALT=1111.
- The package also holds the state enum and the pc_src encodings.
- One sub-module, hazard_detect: purely combinational load-use compare. The FSM and counters stay in the top module.

Test Plan:
- LW r3 in EX, ADD reading r3 (rs1_id=3) in ID -> exactly one cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_cycles=1.
- Same with rd_ex=0 -> no stall. With uses_rs2_id=0 and rs2_id=3 -> no stall.
- BEQ in ID, branch_taken=1 -> pc_src=01, ifid_flush=1 that cycle. JMP -> pc_src=10.
- LW in MEM, mem_ready low 4 cycles -> all writes 0 for 4 cycles, RUN on the 5th; stall_cycles=4.
- Mem wait coincides with load-use: freeze first, then the 1-cycle bubble on exit.
- HALT in ID -> flush, 3 DRAIN cycles with exmem_write=1, then halted=1 held; rst_n low for one edge -> halted=0, stall_cycles=0.
- mem_ready held low 300 cycles -> mem_timeout=1 at cycle 255 and stays set; state returns to RUN.
